// File: rtl/display_mux_ndigit_if.sv
// display_mux_ndigit_if: value/dp request inputs and pin outputs of the multiplexed display driver
interface display_mux_ndigit_if #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0] dp_in;
  logic enable;
  logic [6:0] seg;
  logic dp;
  logic [NUM_DIGITS-1:0] an;
  logic frame_start;
  modport master(output value, dp_in, enable, input seg, dp, an, frame_start);
  modport slave(input value, dp_in, enable, output seg, dp, an, frame_start);
endinterface

// File: rtl/display_mux_ndigit.sv
// display_mux_ndigit: time-multiplexed N-digit hex 7-segment driver with per-frame snapshot
module display_mux_ndigit #(
  parameter int NUM_DIGITS = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW = 0,
  parameter int BLANK_LEADING = 1
) (
  input logic clk,
  input logic rst,
  display_mux_ndigit_if.slave bus
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [6:0] HEX [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic [CW-1:0] count;
  logic [IW-1:0] idx, idx_n;
  logic [4*NUM_DIGITS-1:0] snap, snap_n;
  logic [NUM_DIGITS-1:0] dps, dps_n, za, an_n;
  logic pend, tick, last, load, run, blank, dpa;
  logic [3:0] nib;
  assign tick = count == CW'(REFRESH_DIV - 1);
  assign last = idx == IW'(NUM_DIGITS - 1);
  assign load = pend | (tick & last);
  assign idx_n = tick ? (last ? '0 : idx + IW'(1)) : idx;
  assign snap_n = load ? bus.value : snap;
  assign dps_n = load ? bus.dp_in : dps;
  // Pins are registered from next-state index/snapshot so a new frame's digit 0 lands with frame_start
  always_comb begin
    run = 1'b1;
    za = '0;
    nib = '0;
    blank = 1'b0;
    dpa = 1'b0;
    an_n = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run = run & (snap_n[4*i +: 4] == 4'd0);
      za[i] = run;
    end
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx_n == IW'(i)) begin
        nib = snap_n[4*i +: 4];
        blank = (BLANK_LEADING != 0) && (i > 0) && za[i];
        dpa = dps_n[i];
        an_n[i] = bus.enable;
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      idx <= '0;
      snap <= '0;
      dps <= '0;
      pend <= 1'b1;
      bus.seg <= {7{SEG_ACTIVE_LOW != 0}};
      bus.dp <= SEG_ACTIVE_LOW != 0;
      bus.an <= {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
      bus.frame_start <= 1'b0;
    end else begin
      count <= tick ? '0 : count + CW'(1);
      idx <= idx_n;
      snap <= snap_n;
      dps <= dps_n;
      pend <= 1'b0;
      bus.seg <= ((bus.enable && !blank) ? HEX[nib] : 7'b0) ^ {7{SEG_ACTIVE_LOW != 0}};
      bus.dp <= (bus.enable & dpa) ^ (SEG_ACTIVE_LOW != 0);
      bus.an <= an_n ^ {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
      bus.frame_start <= load;
    end
  end
endmodule

// File: tb/tb_display_mux_ndigit.sv
// tb_display_mux_ndigit: three driver configurations checked cycle by cycle against an arithmetic scan model
module tb_display_mux_ndigit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] v = '0;
  logic [3:0] d4 = '0;
  logic en = 1'b1;
  int tests = 0;
  int fails = 0;
  int k = 0;
  localparam int NN [3] = '{4, 4, 1};
  localparam int DV [3] = '{4, 4, 3};
  localparam int BL [3] = '{1, 0, 1};
  localparam int SA [3] = '{0, 1, 1};
  localparam int AA [3] = '{0, 1, 0};
  localparam logic [6:0] HEX [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic [31:0] snap [3];
  logic [7:0] sdp [3];
  display_mux_ndigit_if #(.NUM_DIGITS(4)) ia();
  display_mux_ndigit_if #(.NUM_DIGITS(4)) ib();
  display_mux_ndigit_if #(.NUM_DIGITS(1)) ic();
  assign ia.value = v;
  assign ia.dp_in = d4;
  assign ia.enable = en;
  assign ib.value = v;
  assign ib.dp_in = d4;
  assign ib.enable = en;
  assign ic.value = v[3:0];
  assign ic.dp_in = d4[0];
  assign ic.enable = en;
  display_mux_ndigit #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0), .BLANK_LEADING(1))
    dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  display_mux_ndigit #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEADING(0))
    dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  display_mux_ndigit #(.NUM_DIGITS(1), .REFRESH_DIV(3), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(0), .BLANK_LEADING(1))
    dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

  function automatic logic [15:0] model(int j, logic [31:0] sv, logic [7:0] sd, int d, logic e);
    logic [6:0] s;
    logic p;
    logic [7:0] a;
    logic [3:0] nib;
    nib = sv[4*d +: 4];
    s = (e && !(BL[j] != 0 && d > 0 && (sv >> (4*d)) == 0)) ? HEX[nib] : 7'b0;
    p = e & sd[d];
    a = e ? 8'(1 << d) : 8'b0;
    if (SA[j] != 0) begin
      s = ~s;
      p = ~p;
    end
    if (AA[j] != 0) a = ~a & 8'((1 << NN[j]) - 1);
    return {a, p, s};
  endfunction

  function automatic logic [16:0] obs(int j);
    if (j == 0) return {4'b0, ia.an, ia.dp, ia.seg, ia.frame_start};
    if (j == 1) return {4'b0, ib.an, ib.dp, ib.seg, ib.frame_start};
    return {7'b0, ic.an, ic.dp, ic.seg, ic.frame_start};
  endfunction

  task automatic cycle();
    logic [16:0] ex [3];
    logic ld;
    for (int j = 0; j < 3; j++) begin
      if (rst) begin
        snap[j] = '0;
        sdp[j] = '0;
        ex[j] = {model(j, 32'd0, 8'd0, 0, 1'b0), 1'b0};
      end else begin
        ld = (k == 0) || (k % (NN[j] * DV[j]) == NN[j] * DV[j] - 1);
        if (ld) begin
          snap[j] = (j == 2) ? 32'(v[3:0]) : 32'(v);
          sdp[j] = (j == 2) ? 8'(d4[0]) : 8'(d4);
        end
        ex[j] = {model(j, snap[j], sdp[j], ((k + 1) / DV[j]) % NN[j], en), ld};
      end
    end
    k = rst ? 0 : k + 1;
    @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      tests++;
      assert (obs(j) === ex[j]) else begin
        fails++;
        $error("FAIL pins%0d k=%0d observed {an,dp,seg,fs}=%h required %h", j, k, obs(j), ex[j]);
      end
    end
    tests++;
    assert ($onehot0(ia.an)) else begin
      fails++;
      $error("FAIL onehot_an observed %b required one-hot or zero", ia.an);
    end
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_digit(int d);
    int b;
    b = 0;
    while (((k / 4) % 4) != d && b < 20) begin
      cycle();
      b++;
    end
    tests++;
    assert (b < 20) else begin
      fails++;
      $error("FAIL wait_digit observed timeout required digit %0d", d);
    end
  endtask

  initial begin
    @(negedge clk);
    v = 16'h1A3F;
    run(3);
    rst = 1'b0;
    run(40);
    wait_digit(1);
    v = 16'h0000;
    run(36);
    v = 16'h0050;
    run(36);
    v = 16'h2C07;
    d4 = 4'b0100;
    run(20);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(30);
    v = 16'h0008;
    d4 = 4'b0000;
    run(20);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(20);
    wait_digit(2);
    v = 16'hB9E4;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(24);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) v = 16'($urandom >> $urandom_range(0, 16));
      if ($urandom_range(0, 7) == 0) d4 = 4'($urandom);
      if ($urandom_range(0, 9) == 0) en = ~en;
      rst = $urandom_range(0, 149) == 0;
      cycle();
    end
    rst = 1'b0;
    run(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
